// File: rtl/mii_frame_pkg.sv
// mii_frame_pkg
// Shared definitions for the MII frame checker: control-character codes,
// the frame FSM state type and the per-lane classification type.
package mii_frame_pkg;

   localparam logic [7:0] CHAR_IDLE  = 8'h07;
   localparam logic [7:0] CHAR_START = 8'hFB;
   localparam logic [7:0] CHAR_TERM  = 8'hFD;
   localparam logic [7:0] CHAR_ERR   = 8'hFE;
   localparam logic [7:0] CHAR_SEQ   = 8'h9C;

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_IN_FRAME
   } state_t;

   typedef enum logic [2:0] {
      LC_DATA,
      LC_IDLE,
      LC_START,
      LC_TERM,
      LC_ERR,
      LC_SEQ,
      LC_OTHER
   } lane_class_t;

endpackage

// File: rtl/mii_lane_classifier.sv
// mii_lane_classifier
// Combinational classification of one MII lane (one byte plus its control flag).
// Ports:
//   txd_i        - lane byte
//   txc_i        - lane control flag (1 = control character)
//   lane_class_o - decoded lane class (LC_DATA when txc_i = 0)
//   pattern_ok_o - byte equals DATA_CHAR_PATTERN (only meaningful for data lanes)
module mii_lane_classifier
   import mii_frame_pkg::*;
#(
   parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA
) (
   input  logic [7:0]  txd_i,
   input  logic        txc_i,
   output lane_class_t lane_class_o,
   output logic        pattern_ok_o
);

   always_comb begin
      pattern_ok_o = (txd_i == DATA_CHAR_PATTERN);
      lane_class_o = LC_OTHER;
      if (!txc_i) begin
         lane_class_o = LC_DATA;
      end else begin
         case (txd_i)
            CHAR_IDLE:  lane_class_o = LC_IDLE;
            CHAR_START: lane_class_o = LC_START;
            CHAR_TERM:  lane_class_o = LC_TERM;
            CHAR_ERR:   lane_class_o = LC_ERR;
            CHAR_SEQ:   lane_class_o = LC_SEQ;
            default:    lane_class_o = LC_OTHER;
         endcase
      end
   end

endmodule

// File: rtl/mii_frame_checker.sv
// mii_frame_checker
// Receive-side frame checker on the recovered 64-bit MII stream. Delineates
// frames from Start (FB) to Terminate (FD), checks payload bytes against a
// fixed data pattern, enforces control-character placement and keeps
// frame-level statistics.
//
// Build option: define MII_FRAME_CHECKER_SAT_EN to make every statistics
// counter saturate at all-ones instead of wrapping.
//
// Ports:
//   clk                 - clock
//   i_rst               - synchronous active-high reset
//   i_valid             - word qualifier
//   i_txd / i_txc       - MII data / per-lane control flags (lane 0 first in time)
//   o_frame_count       - frames closed (good + bad)
//   o_good_frame_count  - frames closed without error
//   o_bad_frame_count   - frames closed with any error
//   o_byte_count        - payload bytes of good frames
//   o_idle_count        - valid all-idle words seen while idle
//   o_pattern_err_count - payload bytes differing from the pattern
//   o_proto_err_count   - words with a placement violation
//   o_frame_done        - one-cycle pulse when a frame closes
//   o_frame_good        - status of last closed frame
//   o_frame_len         - length of last closed frame (saturating)
//   o_in_frame          - FSM is inside a frame
module mii_frame_checker
   import mii_frame_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = 64,
   parameter int unsigned CTRL_WIDTH        = DATA_WIDTH / 8,
   parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
   parameter logic [15:0] MIN_FRAME_BYTES   = 16'd9,
   parameter logic [15:0] MAX_FRAME_BYTES   = 16'd1518,
   parameter int unsigned CNT_WIDTH         = 32
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_txd,
   input  logic [CTRL_WIDTH-1:0] i_txc,
   output logic [CNT_WIDTH-1:0]  o_frame_count,
   output logic [CNT_WIDTH-1:0]  o_good_frame_count,
   output logic [CNT_WIDTH-1:0]  o_bad_frame_count,
   output logic [CNT_WIDTH-1:0]  o_byte_count,
   output logic [CNT_WIDTH-1:0]  o_idle_count,
   output logic [CNT_WIDTH-1:0]  o_pattern_err_count,
   output logic [CNT_WIDTH-1:0]  o_proto_err_count,
   output logic                  o_frame_done,
   output logic                  o_frame_good,
   output logic [15:0]           o_frame_len,
   output logic                  o_in_frame
);

   localparam int unsigned LANES = CTRL_WIDTH;
   localparam int unsigned SUM_W = ((CNT_WIDTH > 16) ? CNT_WIDTH : 16) + 1;

   // Counter add; increments are at most 16 bits wide.
   function automatic logic [CNT_WIDTH-1:0] cnt_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [15:0]          b);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + SUM_W'(b);
`ifdef MII_FRAME_CHECKER_SAT_EN
      if (sum > SUM_W'({CNT_WIDTH{1'b1}})) begin
         return {CNT_WIDTH{1'b1}};
      end
`endif
      return sum[CNT_WIDTH-1:0];
   endfunction

   // ---------------------------------------------------------------------
   // Lane classification
   // ---------------------------------------------------------------------
   lane_class_t lc  [LANES];
   logic        pok [LANES];

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      mii_lane_classifier #(
         .DATA_CHAR_PATTERN (DATA_CHAR_PATTERN)
      ) u_cls (
         .txd_i        (i_txd[8*g +: 8]),
         .txc_i        (i_txc[g]),
         .lane_class_o (lc[g]),
         .pattern_ok_o (pok[g])
      );
   end

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic        bad_q, bad_d;

   // Per-word effects of the current input word.
   logic        idle_hit;
   logic        proto_hit;
   logic [15:0] perr_n;
   logic        close_a;      // frame aborted by FB in lane 0 (always bad)
   logic [15:0] len_a;
   logic        close_b;      // frame terminated by FD
   logic [15:0] len_b;
   logic        bad_b;
   logic        good_b;
   logic        walk;
   logic        after_term;
   logic        trail_bad;
   logic        all_idle;
   logic        ord_set;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      bad_d      = bad_q;
      idle_hit   = 1'b0;
      proto_hit  = 1'b0;
      perr_n     = 16'd0;
      close_a    = 1'b0;
      len_a      = 16'd0;
      close_b    = 1'b0;
      len_b      = 16'd0;
      bad_b      = 1'b0;
      good_b     = 1'b0;
      walk       = 1'b0;
      after_term = 1'b0;
      trail_bad  = 1'b0;
      all_idle   = 1'b1;
      ord_set    = (lc[0] == LC_SEQ);

      for (int i = 0; i < LANES; i++) begin
         if (lc[i] != LC_IDLE) all_idle = 1'b0;
         if (i > 0 && lc[i] != LC_DATA) ord_set = 1'b0;
      end

      if (state_q == ST_IDLE) begin
         if (lc[0] == LC_START) begin
            walk    = 1'b1;
            state_d = ST_IN_FRAME;
         end else if (all_idle) begin
            idle_hit = 1'b1;
         end else if (!ord_set) begin
            // Idle/sequence controls alone are tolerated; anything else is misplaced.
            for (int i = 0; i < LANES; i++) begin
               if (lc[i] != LC_IDLE && lc[i] != LC_SEQ) proto_hit = 1'b1;
            end
         end
      end else begin
         walk = 1'b1;
      end

      if (walk) begin
         for (int i = 0; i < LANES; i++) begin
            if (after_term) begin
               if (lc[i] != LC_IDLE) begin
                  proto_hit = 1'b1;
                  trail_bad = 1'b1;
               end
            end else if (i == 0 && lc[0] == LC_START) begin
               if (state_q == ST_IN_FRAME) begin
                  close_a   = 1'b1;
                  len_a     = len_q;
                  proto_hit = 1'b1;
               end
               len_d = 16'd0;
               bad_d = 1'b0;
            end else begin
               case (lc[i])
                  LC_DATA: begin
                     if (len_d != 16'hFFFF) len_d = len_d + 16'd1;
                     if (!pok[i]) begin
                        perr_n = perr_n + 16'd1;
                        bad_d  = 1'b1;
                     end
                  end
                  LC_TERM: begin
                     after_term = 1'b1;
                     close_b    = 1'b1;
                  end
                  default: begin
                     proto_hit = 1'b1;
                     bad_d     = 1'b1;
                  end
               endcase
            end
         end
      end

      // Trailing-lane violations after FD still count against the closing frame.
      if (close_b) begin
         len_b   = len_d;
         bad_b   = bad_d | trail_bad;
         good_b  = !bad_b && (len_b >= MIN_FRAME_BYTES) && (len_b <= MAX_FRAME_BYTES);
         state_d = ST_IDLE;
         len_d   = 16'd0;
         bad_d   = 1'b0;
      end
   end

   logic [15:0] n_closed;
   logic [15:0] n_bad;

   always_comb begin
      n_closed = {15'd0, close_a} + {15'd0, close_b};
      n_bad    = {15'd0, close_a} + {15'd0, close_b & ~good_b};
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q             <= ST_IDLE;
         len_q               <= 16'd0;
         bad_q               <= 1'b0;
         o_frame_count       <= '0;
         o_good_frame_count  <= '0;
         o_bad_frame_count   <= '0;
         o_byte_count        <= '0;
         o_idle_count        <= '0;
         o_pattern_err_count <= '0;
         o_proto_err_count   <= '0;
         o_frame_done        <= 1'b0;
         o_frame_good        <= 1'b0;
         o_frame_len         <= 16'd0;
      end else begin
         o_frame_done <= 1'b0;
         if (i_valid) begin
            state_q <= state_d;
            len_q   <= len_d;
            bad_q   <= bad_d;
            if (idle_hit)  o_idle_count      <= cnt_add(o_idle_count, 16'd1);
            if (proto_hit) o_proto_err_count <= cnt_add(o_proto_err_count, 16'd1);
            if (perr_n != 16'd0) begin
               o_pattern_err_count <= cnt_add(o_pattern_err_count, perr_n);
            end
            if (close_a || close_b) begin
               o_frame_count     <= cnt_add(o_frame_count, n_closed);
               o_bad_frame_count <= cnt_add(o_bad_frame_count, n_bad);
               o_frame_done      <= 1'b1;
               o_frame_len       <= close_b ? len_b : len_a;
               o_frame_good      <= good_b;
            end
            if (good_b) begin
               o_good_frame_count <= cnt_add(o_good_frame_count, 16'd1);
               o_byte_count       <= cnt_add(o_byte_count, len_b);
            end
         end
      end
   end

   assign o_in_frame = (state_q == ST_IN_FRAME);

endmodule

// File: tb/tb_mii_frame_checker.sv
// tb_mii_frame_checker
// Directed vectors with hand-computed expectations for mii_frame_checker.
// A second, 4-bit-counter instance shares the stimulus to exercise counter
// wrap (or saturation when MII_FRAME_CHECKER_SAT_EN is defined).
module tb_mii_frame_checker;

`ifdef MII_FRAME_CHECKER_SAT_EN
   localparam logic [63:0] SMALL_IDLE_EXP = 64'd15;
`else
   localparam logic [63:0] SMALL_IDLE_EXP = 64'd4;
`endif

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic [63:0] i_txd = 64'd0;
   logic [7:0]  i_txc = 8'd0;

   logic [31:0] frame_cnt, good_cnt, bad_cnt, byte_cnt, idle_cnt, perr_cnt, proto_cnt;
   logic        frame_done, frame_good, in_frame;
   logic [15:0] frame_len;

   logic [3:0]  s_frame_cnt, s_good_cnt, s_bad_cnt, s_byte_cnt, s_idle_cnt, s_perr_cnt;
   logic [3:0]  s_proto_cnt;
   logic        s_frame_done, s_frame_good, s_in_frame;
   logic [15:0] s_frame_len;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   always #5 clk = ~clk;

   mii_frame_checker u_dut (
      .clk                 (clk),
      .i_rst               (i_rst),
      .i_valid             (i_valid),
      .i_txd               (i_txd),
      .i_txc               (i_txc),
      .o_frame_count       (frame_cnt),
      .o_good_frame_count  (good_cnt),
      .o_bad_frame_count   (bad_cnt),
      .o_byte_count        (byte_cnt),
      .o_idle_count        (idle_cnt),
      .o_pattern_err_count (perr_cnt),
      .o_proto_err_count   (proto_cnt),
      .o_frame_done        (frame_done),
      .o_frame_good        (frame_good),
      .o_frame_len         (frame_len),
      .o_in_frame          (in_frame)
   );

   mii_frame_checker #(
      .CNT_WIDTH (4)
   ) u_dut_small (
      .clk                 (clk),
      .i_rst               (i_rst),
      .i_valid             (i_valid),
      .i_txd               (i_txd),
      .i_txc               (i_txc),
      .o_frame_count       (s_frame_cnt),
      .o_good_frame_count  (s_good_cnt),
      .o_bad_frame_count   (s_bad_cnt),
      .o_byte_count        (s_byte_cnt),
      .o_idle_count        (s_idle_cnt),
      .o_pattern_err_count (s_perr_cnt),
      .o_proto_err_count   (s_proto_cnt),
      .o_frame_done        (s_frame_done),
      .o_frame_good        (s_frame_good),
      .o_frame_len         (s_frame_len),
      .o_in_frame          (s_in_frame)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one valid word; it is sampled at the next rising edge.
   task automatic send(input logic [63:0] w, input logic [7:0] c);
      @(negedge clk);
      i_txd   = w;
      i_txc   = c;
      i_valid = 1'b1;
   endtask

   // Idle cycle; on return the outputs reflect the last word sent.
   task automatic gap();
      @(negedge clk);
      i_valid = 1'b0;
      i_txd   = 64'd0;
      i_txc   = 8'd0;
   endtask

   localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
   localparam logic [63:0] W_START = 64'hAAAAAAAAAAAAAAFB;
   localparam logic [63:0] W_DATA  = 64'hAAAAAAAAAAAAAAAA;
   localparam logic [63:0] W_TERM  = 64'h0707070707FDAAAA;

   initial begin
      repeat (2) @(negedge clk);
      @(negedge clk);
      i_rst = 1'b0;

      // Reset state
      check_eq("rst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
      check_eq("rst_idle_cnt", {32'd0, idle_cnt}, 64'd0);
      check_eq("rst_in_frame", {63'd0, in_frame}, 64'd0);
      check_eq("rst_frame_len", {48'd0, frame_len}, 64'd0);
      check_eq("rst_done_good", {62'd0, frame_done, frame_good}, 64'd0);

      // Idle words
      repeat (10) send(W_IDLE, 8'hFF);
      gap();
      check_eq("idle10_idle_cnt", {32'd0, idle_cnt}, 64'd10);
      check_eq("idle10_frame_cnt", {32'd0, frame_cnt}, 64'd0);
      check_eq("idle10_proto", {32'd0, proto_cnt}, 64'd0);
      check_eq("idle10_in_frame", {63'd0, in_frame}, 64'd0);
      repeat (10) send(W_IDLE, 8'hFF);
      gap();
      check_eq("idle20_idle_cnt", {32'd0, idle_cnt}, 64'd20);
      check_eq("small_idle_cnt", {60'd0, s_idle_cnt}, SMALL_IDLE_EXP);

      // Good 25-byte frame
      send(W_START, 8'h01);
      gap();
      check_eq("start_in_frame", {63'd0, in_frame}, 64'd1);
      send(W_DATA, 8'h00);
      send(W_DATA, 8'h00);
      send(W_TERM, 8'hFC);
      gap();
      check_eq("good_done", {63'd0, frame_done}, 64'd1);
      check_eq("good_len", {48'd0, frame_len}, 64'd25);
      check_eq("good_flag", {63'd0, frame_good}, 64'd1);
      check_eq("good_good_cnt", {32'd0, good_cnt}, 64'd1);
      check_eq("good_byte_cnt", {32'd0, byte_cnt}, 64'd25);
      check_eq("good_in_frame", {63'd0, in_frame}, 64'd0);
      gap();
      check_eq("good_done_clear", {63'd0, frame_done}, 64'd0);
      check_eq("good_flag_held", {63'd0, frame_good}, 64'd1);

      // Same frame with one 0x55 payload byte
      send(W_START, 8'h01);
      send(64'hAAAAAAAA55AAAAAA, 8'h00);
      send(W_DATA, 8'h00);
      send(W_TERM, 8'hFC);
      gap();
      check_eq("perr_cnt", {32'd0, perr_cnt}, 64'd1);
      check_eq("perr_bad_cnt", {32'd0, bad_cnt}, 64'd1);
      check_eq("perr_byte_cnt", {32'd0, byte_cnt}, 64'd25);
      check_eq("perr_flag", {63'd0, frame_good}, 64'd0);
      check_eq("perr_frame_cnt", {32'd0, frame_cnt}, 64'd2);

      // FE word mid-frame: len 9 but bad
      send(W_START, 8'h01);
      send(64'hFEFEFEFEFEFEFEFE, 8'hFF);
      send(W_TERM, 8'hFC);
      gap();
      check_eq("fe_proto", {32'd0, proto_cnt}, 64'd1);
      check_eq("fe_bad_cnt", {32'd0, bad_cnt}, 64'd2);
      check_eq("fe_len", {48'd0, frame_len}, 64'd9);
      check_eq("fe_flag", {63'd0, frame_good}, 64'd0);

      // Single-word 3-byte frame: too short
      send(64'h070707FDAAAAAAFB, 8'hF1);
      gap();
      check_eq("short_done", {63'd0, frame_done}, 64'd1);
      check_eq("short_len", {48'd0, frame_len}, 64'd3);
      check_eq("short_flag", {63'd0, frame_good}, 64'd0);
      check_eq("short_bad_cnt", {32'd0, bad_cnt}, 64'd3);
      check_eq("short_proto", {32'd0, proto_cnt}, 64'd1);

      // FB in lane 0 mid-frame aborts the old frame and starts a new one
      send(W_START, 8'h01);
      send(W_START, 8'h01);
      gap();
      check_eq("restart_done", {63'd0, frame_done}, 64'd1);
      check_eq("restart_len", {48'd0, frame_len}, 64'd7);
      check_eq("restart_bad_cnt", {32'd0, bad_cnt}, 64'd4);
      check_eq("restart_proto", {32'd0, proto_cnt}, 64'd2);
      check_eq("restart_in_frame", {63'd0, in_frame}, 64'd1);
      send(W_DATA, 8'h00);
      send(W_TERM, 8'hFC);
      gap();
      check_eq("restart2_len", {48'd0, frame_len}, 64'd17);
      check_eq("restart2_flag", {63'd0, frame_good}, 64'd1);
      check_eq("restart2_byte_cnt", {32'd0, byte_cnt}, 64'd42);
      check_eq("restart2_frame_cnt", {32'd0, frame_cnt}, 64'd6);

      // Data lanes after FD
      send(W_START, 8'h01);
      send(W_DATA, 8'h00);
      send(64'hAAAAAAAAAAAAFDAA, 8'h02);
      gap();
      check_eq("trail_len", {48'd0, frame_len}, 64'd16);
      check_eq("trail_flag", {63'd0, frame_good}, 64'd0);
      check_eq("trail_proto", {32'd0, proto_cnt}, 64'd3);
      check_eq("trail_bad_cnt", {32'd0, bad_cnt}, 64'd5);

      // Data word while idle, then an ordered set
      send(W_DATA, 8'h00);
      gap();
      check_eq("idle_data_proto", {32'd0, proto_cnt}, 64'd4);
      send(64'hAAAAAAAAAAAAAA9C, 8'h01);
      gap();
      check_eq("ordset_proto", {32'd0, proto_cnt}, 64'd4);
      check_eq("ordset_idle_cnt", {32'd0, idle_cnt}, 64'd20);
      check_eq("ordset_in_frame", {63'd0, in_frame}, 64'd0);
      check_eq("final_good_cnt", {32'd0, good_cnt}, 64'd2);
      check_eq("final_perr_cnt", {32'd0, perr_cnt}, 64'd1);

      // Reset mid-frame
      send(W_START, 8'h01);
      send(W_DATA, 8'h00);
      gap();
      check_eq("pre_rst_in_frame", {63'd0, in_frame}, 64'd1);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      check_eq("mid_rst_in_frame", {63'd0, in_frame}, 64'd0);
      check_eq("mid_rst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
      check_eq("mid_rst_idle_cnt", {32'd0, idle_cnt}, 64'd0);
      check_eq("mid_rst_proto", {32'd0, proto_cnt}, 64'd0);
      check_eq("mid_rst_byte_cnt", {32'd0, byte_cnt}, 64'd0);
      check_eq("mid_rst_len", {48'd0, frame_len}, 64'd0);

      // A fresh frame after reset mid-frame starts from zero length
      send(W_START, 8'h01);
      send(W_DATA, 8'h00);
      send(W_TERM, 8'hFC);
      gap();
      check_eq("post_rst_len", {48'd0, frame_len}, 64'd17);
      check_eq("post_rst_frame_cnt", {32'd0, frame_cnt}, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
